// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: opcodes, FSM state encoding and opcode class vector.
// Imported by the PC sequencer and by the branch-condition logic so both agree on opcode values.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_ALU_R = 6'b000000;
  localparam logic [5:0] OP_ALU_I = 6'b000001;
  localparam logic [5:0] OP_SHF   = 6'b000010;
  localparam logic [5:0] OP_BR    = 6'b000011;
  localparam logic [5:0] OP_BMI   = 6'b000100;
  localparam logic [5:0] OP_BPL   = 6'b000101;
  localparam logic [5:0] OP_BZ    = 6'b000110;
  localparam logic [5:0] OP_LD    = 6'b001000;
  localparam logic [5:0] OP_ST    = 6'b001001;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Exactly one bit is set for any opcode.
  typedef struct packed {
    logic alu;
    logic br;
    logic ld;
    logic st;
    logic halt;
    logic nop;
  } opclass_t;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BR) || (op == OP_BMI) || (op == OP_BPL) || (op == OP_BZ);
  endfunction

endpackage

// File: rtl/opclass_decode.sv
// Combinational opcode to one-hot class decode; anything unrecognised is a NOP.
module opclass_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output opclass_t   class_o
);

  always_comb begin
    class_o = '0;
    if (is_branch(opcode_i)) begin
      class_o.br = 1'b1;
    end else begin
      case (opcode_i)
        OP_ALU_R, OP_ALU_I, OP_SHF: class_o.alu  = 1'b1;
        OP_LD:                      class_o.ld   = 1'b1;
        OP_ST:                      class_o.st   = 1'b1;
        OP_HALT:                    class_o.halt = 1'b1;
        default:                    class_o.nop  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer and program counter owner.
// Strobes are pure decodes of the current state plus the relevant memory ready.
module pc_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        pcsel,
  input  logic [31:0] target,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_inc;
  opclass_t    cls;

  opclass_decode u_opclass_decode (
    .opcode_i (opcode),
    .class_o  (cls)
  );

  assign pc_inc = pc_q + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: state_d = ST_EXEC;

      ST_EXEC: begin
        if (cls.halt) begin
          state_d = ST_HALT;
        end else if (cls.ld || cls.st) begin
          state_d = ST_MEM;
        end else if (cls.alu) begin
          state_d = ST_WB;
        end else if (cls.br || cls.nop) begin
          // target is taken verbatim; alignment is the datapath's concern
          pc_d    = (cls.br && pcsel) ? target : pc_inc;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.st;
        if (dmem_rdy) begin
          if (cls.st) begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_inc;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;

      default: state_d = ST_IDLE;
    endcase
  end

  assign pc    = pc_q;
  assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with a retire-ordered scoreboard plus reset/halt sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        pcsel;
  logic [31:0] target;
  logic        imem_rdy, dmem_rdy;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, retire, halted;
  logic [31:0] pc;
  logic [2:0]  state;

  pc_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .pcsel    (pcsel),
    .target   (target),
    .imem_rdy (imem_rdy),
    .dmem_rdy (dmem_rdy),
    .imem_req (imem_req),
    .ir_we    (ir_we),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .rf_we    (rf_we),
    .retire   (retire),
    .halted   (halted),
    .pc       (pc),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        sel;
    logic [31:0] tgt;
    int          iw;    // imem wait cycles
    int          dw;    // dmem wait cycles
    int          lat;   // FETCH entry to retire, inclusive
    int          rf;    // rf_we cycles
    int          dreq;  // dmem_req cycles
    int          dwe;   // dmem_we cycles
    logic [31:0] pc;    // pc visible in the following FETCH
  } vec_t;

  vec_t vecs[13];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge while the DUT sits in FETCH.
  task automatic run_vec(input int idx, input vec_t v);
    int   icnt, dcnt, n_ireq, n_ir, n_dreq, n_dwe, n_rf, lat;
    logic done;
    vec_t e;
    icnt = 0; dcnt = 0; n_ireq = 0; n_ir = 0; n_dreq = 0; n_dwe = 0; n_rf = 0;
    lat = 0; done = 1'b0;
    exp_q.push_back(v);
    opcode = v.op;
    pcsel  = v.sel;
    target = v.tgt;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      imem_rdy = imem_req ? (icnt == v.iw) : 1'($urandom);
      dmem_rdy = dmem_req ? (dcnt == v.dw) : 1'($urandom);
      #1;
      if (imem_req) icnt++;
      if (dmem_req) dcnt++;
      n_ireq += int'(imem_req);
      n_ir   += int'(ir_we);
      n_dreq += int'(dmem_req);
      n_dwe  += int'(dmem_we);
      n_rf   += int'(rf_we);
      if (retire) begin
        lat  = cyc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d retire_seen", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d latency", idx), lat, e.lat);
    chk($sformatf("v%0d imem_req_cycles", idx), n_ireq, e.iw + 1);
    chk($sformatf("v%0d ir_we_cycles", idx), n_ir, 1);
    chk($sformatf("v%0d dmem_req_cycles", idx), n_dreq, e.dreq);
    chk($sformatf("v%0d dmem_we_cycles", idx), n_dwe, e.dwe);
    chk($sformatf("v%0d rf_we_cycles", idx), n_rf, e.rf);
    chk($sformatf("v%0d pc", idx), pc, e.pc);
  endtask

  initial begin
    int   dreq_seen;
    int   halt_bad;
    logic early_retire;
    vec_t v;

    //          op         sel   tgt            iw dw lat rf dreq dwe pc
    vecs[0]  = '{6'b000000, 1'b0, 32'h0000_0000, 0, 0, 4, 1, 0, 0, 32'h0000_0004};
    vecs[1]  = '{6'b000110, 1'b1, 32'h0000_0100, 0, 0, 3, 0, 0, 0, 32'h0000_0100};
    vecs[2]  = '{6'b000110, 1'b0, 32'h0000_0200, 0, 0, 3, 0, 0, 0, 32'h0000_0104};
    vecs[3]  = '{6'b001000, 1'b0, 32'h0000_0000, 0, 3, 8, 1, 4, 0, 32'h0000_0108};
    vecs[4]  = '{6'b001001, 1'b0, 32'h0000_0000, 0, 1, 5, 0, 2, 2, 32'h0000_010C};
    vecs[5]  = '{6'b000001, 1'b0, 32'h0000_0000, 2, 0, 6, 1, 0, 0, 32'h0000_0110};
    vecs[6]  = '{6'b000011, 1'b1, 32'hFFFF_FFFC, 0, 0, 3, 0, 0, 0, 32'hFFFF_FFFC};
    vecs[7]  = '{6'b010101, 1'b1, 32'h0000_0800, 0, 0, 3, 0, 0, 0, 32'h0000_0000};
    vecs[8]  = '{6'b000010, 1'b1, 32'h0000_DEAD, 0, 0, 4, 1, 0, 0, 32'h0000_0004};
    vecs[9]  = '{6'b000100, 1'b1, 32'h0000_0123, 0, 0, 3, 0, 0, 0, 32'h0000_0123};
    vecs[10] = '{6'b000101, 1'b0, 32'h0000_0700, 1, 0, 4, 0, 0, 0, 32'h0000_0127};
    vecs[11] = '{6'b001001, 1'b1, 32'h0000_0500, 0, 0, 4, 0, 1, 1, 32'h0000_012B};
    vecs[12] = '{6'b001000, 1'b0, 32'h0000_0000, 1, 0, 6, 1, 1, 0, 32'h0000_012F};

    rst = 1'b1; opcode = '0; pcsel = 1'b0; target = '0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset state", 32'(state), 32'd0);
    chk("reset pc", pc, 32'h0);
    chk("reset strobes", 32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, retire, halted}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first fetch state", 32'(state), 32'd1);
    chk("first fetch imem_req", 32'(imem_req), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset while a load is waiting on dmem_rdy.
    opcode = 6'b001000;
    dreq_seen = 0;
    for (int c = 0; c < 20 && dreq_seen < 2; c++) begin
      imem_rdy = 1'b1;
      dmem_rdy = 1'b0;
      #1;
      if (dmem_req) dreq_seen++;
      if (dreq_seen < 2) @(negedge clk);
    end
    chk("mem wait reached", dreq_seen, 2);
    rst = 1'b1;
    chk("mem wait no retire", 32'(retire), 32'd0);
    @(negedge clk);
    chk("rst in mem state", 32'(state), 32'd0);
    chk("rst in mem pc", pc, 32'h0);
    chk("rst in mem dmem_req", 32'(dmem_req), 32'd0);
    chk("rst in mem retire", 32'(retire), 32'd0);
    rst = 1'b0;
    imem_rdy = 1'b0;
    @(negedge clk);
    chk("refetch imem_req", 32'(imem_req), 32'd1);

    v = '{6'b000011, 1'b1, 32'h0000_0040, 0, 0, 3, 0, 0, 0, 32'h0000_0040};
    run_vec(13, v);

    // HALT: sticky, ignores everything but rst.
    opcode = 6'b111111;
    pcsel  = 1'b1;
    target = 32'h0000_0999;
    early_retire = 1'b0;
    for (int c = 0; c < 3; c++) begin
      imem_rdy = 1'b1;
      #1;
      early_retire |= retire;
      @(negedge clk);
    end
    chk("halt no retire", 32'(early_retire), 32'd0);
    halt_bad = 0;
    for (int c = 0; c < 12; c++) begin
      pcsel    = 1'($urandom);
      imem_rdy = 1'($urandom);
      dmem_rdy = 1'($urandom);
      target   = $urandom;
      opcode   = 6'($urandom);
      #1;
      if (!halted || imem_req || ir_we || dmem_req || rf_we || retire || pc != 32'h40 || state != 3'd6)
        halt_bad++;
      @(negedge clk);
    end
    chk("halt steady cycles bad", halt_bad, 0);
    chk("halt state", 32'(state), 32'd6);
    chk("halt pc", pc, 32'h40);
    rst = 1'b1;
    @(negedge clk);
    chk("halt cleared", 32'(halted), 32'd0);
    chk("halt rst state", 32'(state), 32'd0);
    chk("halt rst pc", pc, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle control FSM for the RISC core. It sequences fetch, decode, execute, memory and writeback for each instruction, and owns the program counter. At EXEC it consumes the `pcsel` decision from the branch-condition logic and selects either the branch target or PC+4. It sits between the instruction/data memory handshakes and the datapath enables.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential PC increment in bytes

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  opcode field of the instruction register; valid from DECODE onward
- pcsel  in  1  branch-taken decision from the branch-condition logic; sampled only in EXEC
- target  in  32  branch target address; sampled only in EXEC
- imem_rdy  in  1  instruction memory read complete
- dmem_rdy  in  1  data memory access complete
- imem_req  out  1  instruction fetch request, address = pc
- ir_we  out  1  instruction register load strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- rf_we  out  1  register-file write enable
- retire  out  1  one-cycle pulse at instruction completion
- halted  out  1  core halted
- pc  out  32  current program counter
- state  out  3  FSM state, for debug

## Operation
- Opcode classes:
  - ALU: 000000 R-type, 000001 immediate, 000010 shift.
  - BR: 000011 br, 000100 bmi, 000101 bpl, 000110 bz.
  - LD: 001000.
  - ST: 001001.
  - HALT: 111111.
  - Every other opcode is a NOP.
- IDLE: entered on reset. All strobes are 0. Goes to FETCH next cycle.
- FETCH: imem_req=1. Waits for imem_rdy. On imem_rdy: ir_we=1 in the same cycle, then go to DECODE.
- DECODE: one cycle, no strobes. Goes to EXEC.
- EXEC: one cycle.
  - BR: pc<=target if pcsel, else pc<=pc+PC_STEP. retire=1. Go to FETCH.
  - LD or ST: go to MEM.
  - ALU: go to WB.
  - NOP: pc<=pc+PC_STEP, retire=1, go to FETCH.
  - HALT: go to HALT. PC is unchanged.
- MEM: dmem_req=1; dmem_we=1 iff ST. Waits for dmem_rdy. On dmem_rdy:
  - LD goes to WB.
  - ST does pc<=pc+PC_STEP, retire=1, and goes to FETCH.
- WB: rf_we=1 for one cycle, pc<=pc+PC_STEP, retire=1, go to FETCH.
- HALT: halted=1 and no requests. Only rst leaves this state.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. target is loaded verbatim, with no alignment masking.
- pcsel and target are ignored outside EXEC and for non-BR opcodes.
- imem_rdy is ignored outside FETCH. dmem_rdy is ignored outside MEM.
- Opcode changes outside DECODE/EXEC/MEM/WB have no effect.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, and every other output is 0.
- rst asserted in any state, including mid-wait in FETCH or MEM, abandons the instruction. The next cycle is IDLE with reset values and no retire.
- All strobes (imem_req, ir_we, dmem_req, dmem_we, rf_we, retire, halted) are combinational decodes of state plus the relevant rdy input. They carry no extra register stage.
- pc updates on the clock edge that leaves EXEC, MEM (ST) or WB. The new pc is visible in the following FETCH.
- Latency with zero-wait memories (rdy high on first request cycle), counted from entering FETCH to retire:
  - BR and NOP: 3 cycles.
  - ALU and ST: 4 cycles.
  - LD: 5 cycles.
- Each wait cycle on imem_rdy or dmem_rdy adds one cycle.
- First imem_req occurs one cycle after rst deasserts, because of IDLE.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams (OP_ALU_R, OP_ALU_I, OP_SHF, OP_BR, OP_BMI, OP_BPL, OP_BZ, OP_LD, OP_ST, OP_HALT);
  - 3-bit state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- The branch-condition opcode values must come from that package so both blocks agree.
- One sub-module, opclass_decode: combinational opcode to one-hot class (alu, br, ld, st, halt, nop). It is reusable by other control blocks.
- PC register, next-PC mux and FSM live in pc_sequencer.

## Test plan
- Reset then ALU (opcode 000000), imem_rdy and dmem_rdy tied 1 → imem_req in cycle 1 after reset; rf_we and retire in cycle 4; pc 0→4.
- BZ (000110) with pcsel=1, target=32'h0000_0100 → pc=0x100 after EXEC, 3-cycle retire. Repeat with pcsel=0 → pc=4.
- LD with dmem_rdy held low 3 cycles → dmem_req high for 4 cycles, dmem_we=0, rf_we one cycle after dmem_rdy, pc+4. ST → dmem_we=1, no rf_we.
- pc preset by BR to 32'hFFFF_FFFC, then NOP → pc wraps to 0. Unknown opcode 010101 → no rf_we, no dmem_req, retire after 3 cycles.
- rst asserted during MEM wait → next cycle state=IDLE, pc=RESET_PC, dmem_req=0, no retire. Fetch restarts 1 cycle after release.
- HALT (111111) → halted=1 indefinitely, no requests, pc unchanged, pcsel toggling ignored. rst clears halted.
